// File: rtl/mdu_ctrl.sv
// mdu_ctrl: one-op-at-a-time sequencer between execute and the shared multiply/divide datapath.
// Latency: mul MUL_LAT+1 cycles accept->out_valid; div = divider completion + 1; no-op/fast path 1 cycle.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE&&out_ready; flush/rst force 0.
//
// Ports: clk/rst (sync, active-high); in_* op handshake (one-hot in_op, operands, tag); flush cancels all;
// out_* result handshake; busy; mul_* multiplier start/operands/product; div_* divider start/kill/results.
// mul_signed[0] marks src1 as signed, mul_signed[1] marks src2 as signed.
// Optional feature macro: MDU_DIV_FASTPATH_EN resolves divide-by-zero and signed overflow at accept.
module mdu_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [12:0]      in_op,
    input  logic [63:0]      in_src1,
    input  logic [63:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             mul_start,
    output logic [1:0]       mul_signed,
    output logic [63:0]      mul_src1,
    output logic [63:0]      mul_src2,
    input  logic [63:0]      mul_hi,
    input  logic [63:0]      mul_lo,
    output logic             div_start,
    output logic             div_sign,
    output logic             div_shorten,
    output logic [63:0]      div_src1,
    output logic [63:0]      div_src2,
    output logic             div_kill,
    input  logic             div_done,
    input  logic [63:0]      div_quot,
    input  logic [63:0]      div_rem
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
    typedef enum logic [3:0] {
        OP_NONE, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW,
        OP_REM, OP_REMU, OP_REMUW, OP_REMW, OP_DIVW, OP_DIV, OP_DIVU, OP_DIVUW
    } op_e;

    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    // in_op bit order (MSB..LSB): mulh,mulhsu,mulhu,rem,remu,div,divu,remuw,divuw,mul,remw,divw,mulw
    function automatic op_e decode_op(input logic [12:0] v);
        op_e o;
        if      (v[3])  o = OP_MUL;
        else if (v[12]) o = OP_MULH;
        else if (v[11]) o = OP_MULHSU;
        else if (v[10]) o = OP_MULHU;
        else if (v[0])  o = OP_MULW;
        else if (v[9])  o = OP_REM;
        else if (v[8])  o = OP_REMU;
        else if (v[5])  o = OP_REMUW;
        else if (v[2])  o = OP_REMW;
        else if (v[1])  o = OP_DIVW;
        else if (v[7])  o = OP_DIV;
        else if (v[6])  o = OP_DIVU;
        else if (v[4])  o = OP_DIVUW;
        else            o = OP_NONE;
        return o;
    endfunction

    function automatic logic is_mul_op(input op_e o);
        return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    endfunction
    function automatic logic is_div_op(input op_e o);
        return (o != OP_NONE) && !is_mul_op(o);
    endfunction
    function automatic logic is_rem_op(input op_e o);
        return o inside {OP_REM, OP_REMU, OP_REMUW, OP_REMW};
    endfunction
    function automatic logic is_word_div(input op_e o);
        return o inside {OP_REMW, OP_REMUW, OP_DIVW, OP_DIVUW};
    endfunction
    function automatic logic is_signed_div(input op_e o);
        return o inside {OP_REM, OP_REMW, OP_DIV, OP_DIVW};
    endfunction
    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [63:0]        src1_q, src1_d, src2_q, src2_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [63:0]        res_q, res_d;

    op_e                in_kind;
    logic               accept;
    logic               fp_hit;
    logic [63:0]        fp_res;
    logic [63:0]        mul_res, div_sel, div_res;

    assign in_kind  = decode_op(in_op);
    assign in_ready = !rst && !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

`ifdef MDU_DIV_FASTPATH_EN
    // Special cases are judged on the 32-bit operand views for W ops.
    logic        fp_word, fp_zero, fp_ovf;
    logic [63:0] fp_dvd;
    assign fp_word = is_word_div(in_kind);
    assign fp_dvd  = fp_word ? sext32(in_src1[31:0]) : in_src1;
    assign fp_zero = fp_word ? (in_src2[31:0] == '0) : (in_src2 == '0);
    assign fp_ovf  = is_signed_div(in_kind) &&
                     (fp_word ? ((in_src1[31:0] == 32'h8000_0000) && (in_src2[31:0] == 32'hFFFF_FFFF))
                              : ((in_src1 == 64'h8000_0000_0000_0000) && (in_src2 == '1)));
    assign fp_hit  = is_div_op(in_kind) && (fp_zero || fp_ovf);
    assign fp_res  = fp_zero ? (is_rem_op(in_kind) ? fp_dvd : '1)
                             : (is_rem_op(in_kind) ? '0 : fp_dvd);
`else
    assign fp_hit = 1'b0;
    assign fp_res = '0;
`endif

    always_comb begin
        mul_res = mul_lo;
        if (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}) begin
            mul_res = mul_hi;
        end else if (op_q == OP_MULW) begin
            mul_res = sext32(mul_lo[31:0]);
        end
        div_sel = is_rem_op(op_q) ? div_rem : div_quot;
        div_res = is_word_div(op_q) ? sext32(div_sel[31:0]) : div_sel;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        tag_d   = tag_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    res_d   = mul_res;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DIV: begin
                // cnt_q==0 marks the start cycle; a done pulse there belongs to nothing we issued.
                if (cnt_q == '0) begin
                    cnt_d = 4'd1;
                end else if (div_done) begin
                    res_d   = div_res;
                    state_d = S_DONE;
                end
            end
            default: begin // S_DONE
                if (out_ready) state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            op_d   = in_kind;
            src1_d = in_src1;
            src2_d = in_src2;
            tag_d  = in_tag;
            cnt_d  = '0;
            if (is_mul_op(in_kind)) begin
                state_d = S_MUL;
            end else if (in_kind == OP_NONE) begin
                res_d   = '0;
                state_d = S_DONE;
            end else if (fp_hit) begin
                res_d   = fp_res;
                state_d = S_DONE;
            end else begin
                state_d = S_DIV;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            src1_q  <= '0;
            src2_q  <= '0;
            tag_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
        end
    end

    assign out_valid   = (state_q == S_DONE) && !flush;
    assign out_result  = res_q;
    assign out_tag     = tag_q;
    assign busy        = (state_q != S_IDLE);
    assign mul_start   = (state_q == S_MUL) && (cnt_q == '0);
    assign mul_signed  = (op_q inside {OP_MUL, OP_MULH, OP_MULW}) ? 2'b11 :
                         (op_q == OP_MULHSU) ? 2'b01 : 2'b00;
    assign mul_src1    = src1_q;
    assign mul_src2    = src2_q;
    assign div_start   = (state_q == S_DIV) && (cnt_q == '0);
    assign div_sign    = is_signed_div(op_q);
    assign div_shorten = is_word_div(op_q);
    assign div_src1    = src1_q;
    assign div_src2    = src2_q;
    assign div_kill    = (state_q == S_DIV) && flush;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized + directed bench for mdu_ctrl against an arithmetic reference model.
// Latency: n/a (bench).
// Backpressure: bench holds results for random cycles and exercises back-to-back accepts.
module tb_mdu_ctrl;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;
`ifdef MDU_DIV_FASTPATH_EN
    localparam bit FP_EN = 1'b1;
`else
    localparam bit FP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [12:0] in_op = '0;
    logic [63:0] in_src1 = '0, in_src2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic flush = 1'b0;
    logic out_valid, out_ready = 1'b0;
    logic [63:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic busy, mul_start, div_start, div_sign, div_shorten, div_kill;
    logic [1:0] mul_signed;
    logic [63:0] mul_src1, mul_src2, div_src1, div_src2;
    logic [63:0] mul_hi = '0, mul_lo = '0, div_quot = '0, div_rem = '0;
    logic div_done = 1'b0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .busy(busy), .mul_start(mul_start), .mul_signed(mul_signed), .mul_src1(mul_src1),
        .mul_src2(mul_src2), .mul_hi(mul_hi), .mul_lo(mul_lo), .div_start(div_start),
        .div_sign(div_sign), .div_shorten(div_shorten), .div_src1(div_src1), .div_src2(div_src2),
        .div_kill(div_kill), .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bench op index in priority order: mul,mulh,mulhsu,mulhu,mulw,rem,remu,remuw,remw,divw,div,divu,divuw
    function automatic int kbit(input int k);
        case (k)
            0: return 3;   1: return 12;  2: return 11;  3: return 10;  4: return 0;
            5: return 9;   6: return 8;   7: return 5;   8: return 2;   9: return 1;
            10: return 7;  11: return 6;  default: return 4;
        endcase
    endfunction
    function automatic int resolve(input logic [12:0] v);
        for (int k = 0; k < 13; k++) if (v[kbit(k)]) return k;
        return -1;
    endfunction
    function automatic bit k_rem(input int k);  return (k >= 5 && k <= 8); endfunction
    function automatic bit k_word(input int k); return (k == 7 || k == 8 || k == 9 || k == 12); endfunction
    function automatic bit k_sgn(input int k);  return (k == 5 || k == 8 || k == 9 || k == 10); endfunction

    function automatic logic [63:0] riscv_div(input logic [63:0] a, input logic [63:0] b,
                                              input bit sgn, input bit word, input bit isrem);
        logic [63:0] x, y, q, r;
        if (word) begin
            x = sgn ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
            y = sgn ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
        end else begin
            x = a; y = b;
        end
        if (y == 0) begin q = '1; r = x; end
        else if (sgn && x == 64'h8000_0000_0000_0000 && y == '1) begin q = x; r = 0; end
        else if (sgn) begin q = $signed(x) / $signed(y); r = $signed(x) % $signed(y); end
        else begin q = x / y; r = x % y; end
        q = isrem ? r : q;
        return word ? {{32{q[31]}}, q[31:0]} : q;
    endfunction

    function automatic logic [63:0] ref_result(input int k, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        if (k < 0) return 64'd0;
        if (k >= 5) return riscv_div(a, b, k_sgn(k), k_word(k), k_rem(k));
        case (k)
            1: p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
            2: p = {{64{a[63]}}, a} * {64'b0, b};
            3: p = {64'b0, a} * {64'b0, b};
            default: p = {64'b0, a} * {64'b0, b};
        endcase
        if (k == 0) return p[63:0];
        if (k == 4) return {{32{p[31]}}, p[31:0]};
        return p[127:64];
    endfunction

    function automatic bit fp_case(input int k, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x, y;
        if (k_word(k)) begin
            x = {{32{a[31]}}, a[31:0]}; y = {{32{b[31]}}, b[31:0]};
        end else begin
            x = a; y = b;
        end
        if (y == 0) return 1'b1;
        if (k_sgn(k) && y == '1 &&
            (k_word(k) ? (x == 64'hFFFF_FFFF_8000_0000) : (x == 64'h8000_0000_0000_0000))) return 1'b1;
        return 1'b0;
    endfunction

    // Multiplier model: product presented only in the capture cycle, garbage otherwise.
    int mk = 1000;
    always @(negedge clk) begin
        logic [127:0] p;
        if (mul_start) mk = 0; else if (mk < 1000) mk++;
        if (mk == MUL_LAT - 1) begin
            p = (mul_signed[0] ? {{64{mul_src1[63]}}, mul_src1} : {64'b0, mul_src1}) *
                (mul_signed[1] ? {{64{mul_src2[63]}}, mul_src2} : {64'b0, mul_src2});
            mul_hi = p[127:64];
            mul_lo = p[63:0];
        end else begin
            mul_hi = {$urandom, $urandom};
            mul_lo = {$urandom, $urandom};
        end
    end

    // Divider model: done after div_dly cycles; upper half is junk for 32-bit divides.
    int div_dly = 3;
    int dk = 0;
    bit dact = 1'b0;
    bit force_done = 1'b0;
    int done_cyc = 0;
    int kill_n = 0;
    logic [63:0] da, db;
    bit dsg, dsh;
    always @(negedge clk) begin
        logic [63:0] q, r;
        div_done = 1'b0;
        div_quot = {$urandom, $urandom};
        div_rem  = {$urandom, $urandom};
        if (div_kill) begin dact = 1'b0; kill_n++; end
        if (div_start && !div_kill) begin
            dact = 1'b1; dk = 0; da = div_src1; db = div_src2; dsg = div_sign; dsh = div_shorten;
        end else if (dact) begin
            dk++;
            if (dk == div_dly) begin
                q = riscv_div(da, db, dsg, dsh, 1'b0);
                r = riscv_div(da, db, dsg, dsh, 1'b1);
                div_quot = dsh ? {$urandom, q[31:0]} : q;
                div_rem  = dsh ? {$urandom, r[31:0]} : r;
                div_done = 1'b1;
                dact = 1'b0;
                done_cyc = cyc;
            end
        end
        if (force_done) div_done = 1'b1;
    end

    // Entered and left at #1 after a rising edge; leaves the result held in DONE.
    task automatic run_op(input logic [12:0] opv, input logic [63:0] a, input logic [63:0] b,
                          input int hold, input int dly);
        int k, t_acc, n, ms_n, ds_n, ms_c, ds_c, exp_lat;
        bit fast, stable;
        logic [63:0] exp;
        logic [TAG_W-1:0] tg;
        k = resolve(opv);
        tg = TAG_W'($urandom);
        exp = ref_result(k, a, b);
        fast = (k < 0) || (k >= 5 && FP_EN && fp_case(k, a, b));
        div_dly = dly;
        in_valid = 1'b1; in_op = opv; in_src1 = a; in_src2 = b; in_tag = tg; out_ready = 1'b1;
        @(negedge clk);
        chk_eq("acc_rdy", in_ready, 1);
        t_acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_op = 13'($urandom); in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
        ms_n = 0; ds_n = 0; ms_c = 0; ds_c = 0; n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            if (mul_start) begin
                ms_n++; ms_c = cyc;
                chk_eq("mul_signed", mul_signed, (k == 2) ? 2'b01 : (k == 3) ? 2'b00 : 2'b11);
            end
            if (div_start) begin
                ds_n++; ds_c = cyc;
                chk_eq("div_sign", div_sign, k_sgn(k));
                chk_eq("div_shorten", div_shorten, k_word(k));
            end
            n++;
            @(negedge clk);
        end
        chk_eq("vld_seen", out_valid, 1);
        if (k >= 0 && k <= 4) exp_lat = MUL_LAT + 1;
        else if (fast) exp_lat = 1;
        else exp_lat = done_cyc + 1 - t_acc;
        chk_eq("latency", cyc - t_acc, exp_lat);
        chk_eq("mul_start_n", ms_n, (k >= 0 && k <= 4));
        chk_eq("div_start_n", ds_n, (k >= 5 && !fast));
        if (ms_n == 1) chk_eq("mul_start_cyc", ms_c, t_acc + 1);
        if (ds_n == 1) chk_eq("div_start_cyc", ds_c, t_acc + 1);
        chk_eq("result", out_result, exp);
        chk_eq("tag", out_tag, tg);
        chk_eq("busy_done", busy, 1);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!(out_valid && out_result == exp && out_tag == tg)) stable = 1'b0;
        end
        if (hold > 0) chk_eq("hold_stable", stable, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 8))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {$urandom, 32'h8000_0000};
            4: return {$urandom, 32'hFFFF_FFFF};
            5: return {32'b0, 32'($urandom_range(0, 20))};
            6: return {$urandom, 32'h0};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int kill0;
        bit seen;
        logic [12:0] opv;
        int r;
        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_in_ready", in_ready, 0);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_starts", {mul_start, div_start, div_kill}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_in_ready", in_ready, 1);
        chk_eq("post_rst_result", out_result, 0);
        chk_eq("post_rst_tag", out_tag, 0);
        chk_eq("post_rst_mul_signed", mul_signed, 0);
        @(posedge clk); #1;

        // Directed cases
        run_op(13'd1 << 3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1);
        chk_eq("mul_7x-3", out_result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(13'd1 << 4, 64'h1_0000_0010, 64'd3, 0, 33);
        chk_eq("divuw_const", out_result, 64'h5);
        run_op(13'd1 << 7, 64'd1234, 64'd0, 0, 4);
        chk_eq("div_by_zero", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(13'd1 << 2, 64'h8000_0000, 64'hFFFF_FFFF, 0, 2);
        chk_eq("remw_ovf", out_result, 64'h0);
        run_op(13'd0, 64'd55, 64'd66, 1, 1);
        chk_eq("none_zero", out_result, 64'h0);
        // Held 5 cycles, then released together with a new mul (back-to-back)
        run_op(13'd1 << 12, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 5, 1);
        run_op(13'd1 << 3, 64'd9, 64'd11, 1, 1);
        chk_eq("b2b_mul", out_result, 64'd99);

        // Flush two cycles into DIV, then a stray div_done
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        in_valid = 1'b1; in_op = 13'd1 << 7; in_src1 = 64'd100; in_src2 = 64'd7; div_dly = 40;
        @(negedge clk);
        chk_eq("fl_acc_rdy", in_ready, 1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; flush = 1'b1; kill0 = kill_n;
        @(negedge clk);
        chk_eq("fl_kill", div_kill, 1);
        chk_eq("fl_in_rdy", in_ready, 0);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk_eq("fl_busy", busy, 0);
        @(posedge clk); #1; force_done = 1'b1;
        @(posedge clk); #1; force_done = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (out_valid || busy) seen = 1'b1; end
        chk_eq("fl_quiet", seen, 0);
        chk_eq("fl_kill_n", kill_n - kill0, 1);
        @(posedge clk); #1;

        // Flush wins over out_ready + in_valid in DONE
        run_op(13'd1 << 10, 64'd3, 64'd5, 1, 1);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_op = 13'd1 << 3;
        @(negedge clk);
        chk_eq("fl_done_in_rdy", in_ready, 0);
        @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_eq("fl_done_vld", out_valid, 0);
        chk_eq("fl_done_busy", busy, 0);
        @(posedge clk); #1;

        // Randomized ops
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 15);
            if (r < 13) opv = 13'd1 << kbit(r);
            else if (r == 13) opv = 13'd0;
            else opv = 13'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            run_op(opv, pick(), pick(), $urandom_range(0, 3), $urandom_range(1, 8));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller between the execute stage and the shared multiply/divide datapath. Accepts one op at a time over a valid/ready handshake. Drives the fixed-latency multiplier and the iterative divider, and resolves RISC-V divide special cases. It formats 64-bit and W results and holds each result until the writeback side accepts it. Pipeline flushes cancel in-flight work, including killing a running division.

## Interface

Parameters:
- MUL_LAT, default 2: cycles from mul_start until mul_hi/mul_lo are valid (legal range 1–15).
- TAG_W, default 5: width of the destination tag carried with each op.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  op offered.
- in_ready  out  1  controller can accept an op.
- in_op  in  13  one-hot {mulh,mulhsu,mulhu,rem,remu,div,divu,remuw,divuw,mul,remw,divw,mulw}.
- in_src1, in_src2  in  64  operands; src1 is the dividend or multiplicand.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  cancel everything.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_result  out  64  formatted result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_signed  out  2  signedness: 11 for mul/mulh/mulw, 01 for mulhsu, 00 for mulhu.
- mul_src1, mul_src2  out  64  latched operands, stable through MUL.
- mul_hi, mul_lo  in  64  product halves.
- div_start  out  1  one-cycle start pulse to the divider.
- div_sign  out  1  signed divide: rem, remw, div, divw.
- div_shorten  out  1  32-bit divide: remw, remuw, divw, divuw.
- div_src1, div_src2  out  64  latched operands, stable through DIV.
- div_kill  out  1  one-cycle abort of the divider.
- div_done  in  1  quotient and remainder are valid this cycle.
- div_quot, div_rem  in  64  divider outputs.

## Operation

- States: IDLE, MUL, DIV, DONE.
- in_ready is true when state is IDLE, or when state is DONE and out_ready is high. It is forced 0 when flush or rst is high.
- An op is accepted in a cycle where in_valid and in_ready are both high. On accept, op, operands and tag are latched.
- Multi-hot in_op is resolved by priority: mul, mulh, mulhsu, mulhu, mulw, rem, remu, remuw, remw, divw, div, divu, divuw.
- An all-zero in_op is still accepted. It goes straight to DONE with result 0.
- Transitions:
  - IDLE or DONE, on accept of a multiply op: MUL.
  - IDLE or DONE, on accept of a divide op: DIV, or DONE directly when the fast path applies (see Configuration).
  - DONE, on out_ready with no new accept: IDLE.
- MUL: mul_start is high in the first MUL cycle, and a counter runs 0..MUL_LAT-1. When the counter reaches MUL_LAT-1, the product is captured and the next state is DONE.
  - mul returns mul_lo.
  - mulh, mulhsu and mulhu return mul_hi.
  - mulw returns sext(mul_lo[31:0]).
- DIV: div_start is high in the first DIV cycle. The controller waits for div_done, which may arrive from the following cycle onward, then captures and moves to DONE.
  - Quotient ops return div_quot; remainder ops return div_rem.
  - W ops return sext(x[31:0]) of the selected output.
- div_done arriving outside DIV is ignored.
- DONE: out_valid is high and out_result/out_tag are stable until out_ready.
- flush in any state: next state IDLE, out_valid drops, the result is discarded and nothing is accepted. If state was DIV, div_kill is high for that same cycle.
- Reset: state IDLE, counter 0. All outputs are 0, except in_ready, which is 1 from the first cycle after rst falls.

## Timing

- Accept in cycle T.
- Multiply: mul_start is high at T+1 and out_valid rises at T+1+MUL_LAT.
- Divide: div_start is high at T+1. If div_done is high at cycle D, out_valid rises at D+1.
- Fast path: out_valid rises at T+1.
- Back-to-back: when out_ready and in_valid coincide in DONE, the next op starts at T+1. No bubble is inserted.
- Simultaneous flush and out_ready in DONE: flush wins and there is no new accept.

## Configuration

- MDU_DIV_FASTPATH_EN defined: special cases are resolved at accept without starting the divider. The check uses 32-bit operand views for W ops.
  - Divide by zero: quotient is all ones. Remainder is the dividend (sext of src1[31:0] for W ops).
  - Signed overflow (most-negative dividend divided by -1): quotient is the dividend. Remainder is 0.
- MDU_DIV_FASTPATH_EN undefined: every divide goes through DIV. Results come from the divider outputs.

## Test plan

- mul with src1=7, src2=-3, MUL_LAT=2: out_result 0xFFFFFFFFFFFFFFEB at T+3; mul_start high only at T+1.
- divuw with src1=0x1_0000_0010 and src2=3, divider asserting div_done 33 cycles after start: out_result 0x5 at D+1; div_shorten=1 and div_sign=0.
- div with src2=0: fast path enabled gives 0xFFFFFFFFFFFFFFFF at T+1 with no div_start. Fast path disabled gives div_start at T+1.
- remw with src1=0x80000000 and src2=0xFFFFFFFF, fast path enabled: out_result 0 at T+1.
- flush two cycles into DIV: div_kill pulses once, busy is 0 the next cycle and no out_valid follows. A late div_done is ignored.
- out_ready held low for 5 cycles in DONE: result and tag stay stable. When out_ready rises together with a new in_valid, the new op is accepted that cycle and mul_start follows next cycle.
